// File: rtl/keypad_pkg.sv
// Shared key codes, entry FSM encoding and digit limit for the keypad decimal entry block.
package keypad_pkg;

   localparam int MAX_DIGITS = 5;

   localparam logic [3:0] KEY_0    = 4'd0;
   localparam logic [3:0] KEY_1    = 4'd1;
   localparam logic [3:0] KEY_2    = 4'd2;
   localparam logic [3:0] KEY_3    = 4'd3;
   localparam logic [3:0] KEY_4    = 4'd4;
   localparam logic [3:0] KEY_5    = 4'd5;
   localparam logic [3:0] KEY_6    = 4'd6;
   localparam logic [3:0] KEY_7    = 4'd7;
   localparam logic [3:0] KEY_8    = 4'd8;
   localparam logic [3:0] KEY_9    = 4'd9;
   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   typedef enum logic [1:0] {
      ST_ENTRY = 2'd0,
      ST_CONV  = 2'd1,
      ST_DONE  = 2'd2
   } entry_state_t;

   // Physical keypad layout: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
   function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'd0:    code = KEY_1;
         4'd1:    code = KEY_2;
         4'd2:    code = KEY_3;
         4'd3:    code = KEY_A;
         4'd4:    code = KEY_4;
         4'd5:    code = KEY_5;
         4'd6:    code = KEY_6;
         4'd7:    code = KEY_B;
         4'd8:    code = KEY_7;
         4'd9:    code = KEY_8;
         4'd10:   code = KEY_9;
         4'd11:   code = KEY_C;
         4'd12:   code = KEY_STAR;
         4'd13:   code = KEY_0;
         4'd14:   code = KEY_HASH;
         default: code = KEY_D;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scan of the 4x4 keypad with per-scan classification and press/release debounce.
// Emits a one-cycle key_evt_o with key_code_o for each accepted press.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50_000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] rows_i,
   output logic [3:0] cols_o,
   output logic       key_evt_o,
   output logic [3:0] key_code_o
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   logic [DW-1:0] r_dwell;
   logic [1:0]    r_col;
   logic [1:0]    r_hits;
   logic [3:0]    r_code;
   logic          r_pressed;
   logic [3:0]    r_cand;
   logic [CW-1:0] r_deb_cnt;
   logic          r_evt;
   logic [3:0]    r_evt_code;

   logic          w_tick;
   logic [3:0]    w_row_hit;
   logic [2:0]    w_col_hits;
   logic [3:0]    w_col_code;
   logic [2:0]    w_sum;
   logic [1:0]    w_scan_hits;
   logic [3:0]    w_scan_code;
   logic [CW-1:0] w_run;
   logic [CW-1:0] w_press_run;

   assign w_tick    = (r_dwell == DW'(SCAN_DIV - 1));
   assign w_row_hit = ~rows_i;

   always_comb begin
      w_col_code = KEY_0;
      for (int r = 3; r >= 0; r--) begin
         if (w_row_hit[r]) w_col_code = key_at(2'(r), r_col);
      end
   end

   assign w_col_hits = {2'b00, w_row_hit[0]} + {2'b00, w_row_hit[1]}
                     + {2'b00, w_row_hit[2]} + {2'b00, w_row_hit[3]};

   // Hit count saturates at 2: anything beyond one key is simply "invalid".
   assign w_sum       = {1'b0, r_hits} + w_col_hits;
   assign w_scan_hits = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
   assign w_scan_code = (r_hits != 2'd0) ? r_code : w_col_code;

   assign w_run       = r_deb_cnt + CW'(1);
   assign w_press_run = ((r_deb_cnt != '0) && (w_scan_code == r_cand)) ? w_run : CW'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_dwell    <= '0;
         r_col      <= 2'd0;
         r_hits     <= 2'd0;
         r_code     <= 4'd0;
         r_pressed  <= 1'b0;
         r_cand     <= 4'd0;
         r_deb_cnt  <= '0;
         r_evt      <= 1'b0;
         r_evt_code <= 4'd0;
      end else begin
         r_evt <= 1'b0;
         if (w_tick) begin
            r_dwell <= '0;
            r_col   <= r_col + 2'd1;
            if (r_col == 2'd3) begin
               r_hits <= 2'd0;
               r_code <= 4'd0;
               case (w_scan_hits)
                  2'd1: begin
                     if (r_pressed) begin
                        r_deb_cnt <= '0;
                     end else if (w_press_run == CW'(DEBOUNCE_SCANS)) begin
                        r_evt      <= 1'b1;
                        r_evt_code <= w_scan_code;
                        r_pressed  <= 1'b1;
                        r_deb_cnt  <= '0;
                     end else begin
                        r_cand    <= w_scan_code;
                        r_deb_cnt <= w_press_run;
                     end
                  end
                  2'd0: begin
                     if (!r_pressed) begin
                        r_deb_cnt <= '0;
                     end else if (w_run == CW'(DEBOUNCE_SCANS)) begin
                        r_pressed <= 1'b0;
                        r_deb_cnt <= '0;
                     end else begin
                        r_deb_cnt <= w_run;
                     end
                  end
                  default: r_deb_cnt <= '0;
               endcase
            end else begin
               r_hits <= w_scan_hits;
               r_code <= w_scan_code;
            end
         end else begin
            r_dwell <= r_dwell + DW'(1);
         end
      end
   end

   assign cols_o     = ~(4'b0001 << r_col);
   assign key_evt_o  = r_evt;
   assign key_code_o = r_evt_code;

endmodule

// File: rtl/keypad_dec_entry.sv
// Keypad decimal entry: collects up to five BCD digits and converts them to a saturated 16-bit value.
// Define KEYPAD_BACKSPACE_EN to make 'D' delete the most recent digit.
//
// state    | meaning
// ST_ENTRY | collecting digits, '*' clears, '#' starts conversion
// ST_CONV  | five multiply-by-ten-and-add steps, most significant digit first
// ST_DONE  | one cycle: valid strobe, digit buffer clears
module keypad_dec_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50_000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  rows_i,
   output logic [3:0]  cols_o,
   output logic [19:0] bcd_o,
   output logic [2:0]  digit_cnt_o,
   output logic        busy_o,
   output logic [15:0] value_o,
   output logic        valid_o,
   output logic        ovf_o
);

   logic         w_key_evt;
   logic [3:0]   w_key_code;

   entry_state_t r_state, w_state_nxt;
   logic [19:0]  r_bcd, w_bcd_nxt;
   logic [2:0]   r_cnt, w_cnt_nxt;
   logic [16:0]  r_acc, w_acc_nxt;
   logic [2:0]   r_idx, w_idx_nxt;
   logic [15:0]  r_value, w_value_nxt;
   logic         r_ovf, w_ovf_nxt;
   logic         w_busy, w_valid;
   logic [3:0]   w_digit;
   logic [16:0]  w_acc_step;

   keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_scanner (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rows_i     (rows_i),
      .cols_o     (cols_o),
      .key_evt_o  (w_key_evt),
      .key_code_o (w_key_code)
   );

   // Buffer stays intact through CONV so it can be read digit by digit.
   assign w_digit    = r_bcd[{r_idx, 2'b00} +: 4];
   assign w_acc_step = (r_acc << 3) + (r_acc << 1) + {13'd0, w_digit};

   always_comb begin
      w_state_nxt = r_state;
      w_bcd_nxt   = r_bcd;
      w_cnt_nxt   = r_cnt;
      w_acc_nxt   = r_acc;
      w_idx_nxt   = r_idx;
      w_value_nxt = r_value;
      w_ovf_nxt   = r_ovf;
      w_busy      = 1'b0;
      w_valid     = 1'b0;
      case (r_state)
         ST_ENTRY: begin
            if (w_key_evt) begin
               if (w_key_code <= KEY_9) begin
                  if (r_cnt < 3'(MAX_DIGITS)) begin
                     w_bcd_nxt = {r_bcd[15:0], w_key_code};
                     w_cnt_nxt = r_cnt + 3'd1;
                  end
               end else if (w_key_code == KEY_STAR) begin
                  w_bcd_nxt = 20'd0;
                  w_cnt_nxt = 3'd0;
               end else if (w_key_code == KEY_HASH) begin
                  w_state_nxt = ST_CONV;
                  w_acc_nxt   = 17'd0;
                  w_idx_nxt   = 3'(MAX_DIGITS - 1);
`ifdef KEYPAD_BACKSPACE_EN
               end else if ((w_key_code == KEY_D) && (r_cnt != 3'd0)) begin
                  w_bcd_nxt = {4'h0, r_bcd[19:4]};
                  w_cnt_nxt = r_cnt - 3'd1;
`endif
               end
            end
         end
         ST_CONV: begin
            w_busy    = 1'b1;
            w_acc_nxt = w_acc_step;
            if (r_idx == 3'd0) begin
               w_state_nxt = ST_DONE;
               // Five digits top out at 99999, so bit 16 alone flags overflow.
               w_value_nxt = w_acc_step[16] ? 16'hFFFF : w_acc_step[15:0];
               w_ovf_nxt   = w_acc_step[16];
            end else begin
               w_idx_nxt = r_idx - 3'd1;
            end
         end
         ST_DONE: begin
            w_valid     = 1'b1;
            w_bcd_nxt   = 20'd0;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = ST_ENTRY;
         end
         default: w_state_nxt = ST_ENTRY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_ENTRY;
         r_bcd   <= 20'd0;
         r_cnt   <= 3'd0;
         r_acc   <= 17'd0;
         r_idx   <= 3'd0;
         r_value <= 16'd0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_bcd   <= w_bcd_nxt;
         r_cnt   <= w_cnt_nxt;
         r_acc   <= w_acc_nxt;
         r_idx   <= w_idx_nxt;
         r_value <= w_value_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   assign bcd_o       = r_bcd;
   assign digit_cnt_o = r_cnt;
   assign busy_o      = w_busy;
   assign valid_o     = w_valid;
   assign value_o     = r_value;
   assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_keypad_dec_entry.sv
// Bench for keypad_dec_entry: a physical keypad model drives the rows, a digit-list model predicts results.
module tb_keypad_dec_entry;

   localparam int SD = 3;
   localparam int DB = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [19:0] bcd;
   logic [2:0]  dcnt;
   logic        busy;
   logic [15:0] value;
   logic        valid;
   logic        ovf;

   logic [15:0] key_mask = 16'd0;
   string       keymap = "123A456B789C*0#D";

   int checks = 0;
   int errors = 0;

   int unsigned q[$];

   int          busy_run  = 0;
   int          last_run  = -1;
   int          valid_cnt = 0;
   logic [15:0] cap_val   = 16'd0;
   logic        cap_ovf   = 1'b0;
   logic        after_valid = 1'b0;
   logic [19:0] bcd_after = 20'd0;
   logic [2:0]  cnt_after = 3'd0;

   keypad_dec_entry #(
      .SCAN_DIV       (SD),
      .DEBOUNCE_SCANS (DB)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .rows_i      (rows),
      .cols_o      (cols),
      .bcd_o       (bcd),
      .digit_cnt_o (dcnt),
      .busy_o      (busy),
      .value_o     (value),
      .valid_o     (valid),
      .ovf_o       (ovf)
   );

   always #5 clk = ~clk;

   // Passive switch matrix: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!cols[c] && key_mask[r*4+c]) rows[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (after_valid) begin
         bcd_after   = bcd;
         cnt_after   = dcnt;
         after_valid = 1'b0;
      end
      if (busy) begin
         busy_run++;
      end else begin
         if (valid) begin
            last_run    = busy_run;
            valid_cnt++;
            cap_val     = value;
            cap_ovf     = ovf;
            after_valid = 1'b1;
         end
         busy_run = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pos_of(input byte ch);
      for (int i = 0; i < 16; i++) if (keymap[i] == ch) return i;
      return 0;
   endfunction

   function automatic logic [19:0] model_bcd();
      logic [19:0] b = 20'd0;
      foreach (q[i]) b = (b << 4) | 20'(q[i]);
      return b;
   endfunction

   function automatic int unsigned model_value();
      int unsigned v = 0;
      foreach (q[i]) v = v * 10 + q[i];
      return v;
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input byte ch);
      key_mask = 16'd1 << pos_of(ch);
      cycles(60);
      key_mask = 16'd0;
      cycles(60);
      if (ch >= "0" && ch <= "9") begin
         if (q.size() < 5) q.push_back(int'(ch - "0"));
      end else if (ch == "*") begin
         q.delete();
      end
`ifdef KEYPAD_BACKSPACE_EN
      else if (ch == "D") begin
         if (q.size() > 0) void'(q.pop_back());
      end
`endif
   endtask

   task automatic check_entry(input string tag);
      check({tag, "_bcd"}, 32'(bcd), 32'(model_bcd()));
      check({tag, "_cnt"}, 32'(dcnt), q.size());
   endtask

   task automatic check_result(input string tag, input int vc0, input int unsigned exp_v);
      check({tag, "_valid_pulses"}, valid_cnt - vc0, 1);
      check({tag, "_value"}, 32'(cap_val), (exp_v > 65535) ? 32'hFFFF : exp_v);
      check({tag, "_ovf"}, 32'(cap_ovf), (exp_v > 65535) ? 1 : 0);
      check({tag, "_busy_len"}, last_run, 5);
      check({tag, "_bcd_after"}, 32'(bcd_after), 0);
      check({tag, "_cnt_after"}, 32'(cnt_after), 0);
      q.delete();
      check({tag, "_bcd_idle"}, 32'(bcd), 0);
   endtask

   task automatic enter(input string tag);
      int unsigned exp_v;
      int vc0;
      exp_v = model_value();
      vc0   = valid_cnt;
      press("#");
      check_result(tag, vc0, exp_v);
   endtask

   task automatic hold_hash_until_busy(input string tag);
      int k;
      key_mask = 16'd1 << pos_of("#");
      for (k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (busy) break;
      end
      check({tag, "_busy_seen"}, 32'(busy), 1);
   endtask

   initial begin
      int vc0;
      int unsigned exp_v;
      int n;

      rst = 1'b1;
      cycles(3);
      check("rst_cols", 32'(cols), 32'hE);
      check("rst_bcd", 32'(bcd), 0);
      check("rst_cnt", 32'(dcnt), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_value", 32'(value), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_ovf", 32'(ovf), 0);
      rst = 1'b0;

      press("1"); press("2"); press("3");
      check_entry("e123");
      check("e123_lit", 32'(bcd), 32'h00123);
      enter("v123");

      press("6"); press("5"); press("5"); press("3"); press("5");
      enter("v65535");

      press("6"); press("5"); press("5"); press("3"); press("6");
      press("7");
      check_entry("sixth");
      check("sixth_lit", 32'(bcd), 32'h65536);
      enter("v65536");

      key_mask = 16'd1 << pos_of("5");
      cycles(6);
      key_mask = 16'd0;
      cycles(6);
      key_mask = 16'd1 << pos_of("5");
      cycles(240);
      key_mask = 16'd0;
      cycles(60);
      q.push_back(5);
      check_entry("bounce_hold");
      check("bounce_cnt_lit", 32'(dcnt), 1);

      key_mask = (16'd1 << pos_of("1")) | (16'd1 << pos_of("2"));
      cycles(60);
      key_mask = 16'd0;
      cycles(60);
      check_entry("two_keys");

      press("4"); press("2");
      check_entry("pre_star");
      press("*");
      check_entry("star");
      check("star_bcd_lit", 32'(bcd), 0);

      enter("empty");

      press("3");
      exp_v = model_value();
      vc0   = valid_cnt;
      hold_hash_until_busy("conv9");
      key_mask = key_mask | (16'd1 << pos_of("9"));
      cycles(60);
      key_mask = 16'd1 << pos_of("9");
      cycles(60);
      key_mask = 16'd0;
      cycles(60);
      check_result("conv9", vc0, exp_v);
      check("conv9_cnt", 32'(dcnt), 0);

      press("4"); press("2");
      hold_hash_until_busy("rstconv");
      vc0 = valid_cnt;
      rst = 1'b1;
      key_mask = 16'd0;
      cycles(1);
      check("rstconv_cols", 32'(cols), 32'hE);
      check("rstconv_bcd", 32'(bcd), 0);
      check("rstconv_cnt", 32'(dcnt), 0);
      check("rstconv_busy", 32'(busy), 0);
      check("rstconv_value", 32'(value), 0);
      check("rstconv_ovf", 32'(ovf), 0);
      check("rstconv_valid", 32'(valid), 0);
      cycles(50);
      rst = 1'b0;
      cycles(100);
      check("rstconv_no_valid", valid_cnt - vc0, 0);
      q.delete();

      press("4"); press("2"); press("D");
      check_entry("bksp");
`ifdef KEYPAD_BACKSPACE_EN
      check("bksp_lit", 32'(bcd), 32'h00004);
`else
      check("bksp_lit", 32'(bcd), 32'h00042);
`endif
      press("*");

      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(0, 6);
         for (int d = 0; d < n; d++) press(byte'("0" + $urandom_range(0, 9)));
         check_entry($sformatf("rnd%0d", it));
         enter($sformatf("rnd%0d", it));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
